character_renderer: RTL
=======================

CHARACTER_RENDERER -- requirements
Module: character_renderer

Interface
REQ-001 Parameters (name, default, meaning): PHY_WIDTH, 10, physics width minus one (signed bus is PHY_WIDTH+1 bits); PIXEL_WIDTH, 12, RGB width; CHAR_WIDTH_X, 32, sprite width; CHAR_WIDTH_Y, 32, sprite height; Y_ORIGIN, 479, screen row where physics y=0; ANIM_DIV, 8, frames per walk phase.
REQ-002 Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
REQ-003 Ports (name, direction, width, meaning):
- sys_clk, in, 1, pixel clock.
- sys_rst_n, in, 1, async active-low reset.
- frame_start, in, 1, one-cycle pulse at the start of vertical blank.
- pixel_valid, in, 1, pixel_x/pixel_y/bg_rgb are valid this cycle.
- pixel_x, in, 10, screen column 0..639.
- pixel_y, in, 10, screen row 0..479.
- bg_rgb, in, PIXEL_WIDTH, background colour for this pixel.
- char_pos_x, in, PHY_WIDTH+1 signed, sprite left column in screen x.
- char_pos_y, in, PHY_WIDTH+1 signed, sprite bottom in physics y (y up).
- char_face, in, 2 signed, 1 = face left, -1 = face right, 0 = none.
- char_state, in, 4, physics FSM state (0 IDLE, 1 LEFT, 2 RIGHT, 3 CHARGE, 4 JUMP, 5 COLLISION, 6 FALL_TO_GROUND).
- rgb_out, out, PIXEL_WIDTH, composited colour.
- rgb_valid, out, 1, rgb_out is valid.
- in_sprite, out, 1, rgb_out comes from an opaque sprite texel.

Function
REQ-004 Character inputs SHALL be sampled into shadow registers only on a cycle with frame_start=1; all rendering SHALL use shadow values only.
REQ-005 A shadow_valid flag SHALL set on the first frame_start; while it is 0, no sprite SHALL be drawn (rgb_out = bg_rgb).
REQ-006 Screen top row SHALL be top = Y_ORIGIN - char_pos_y - (CHAR_WIDTH_Y-1), computed in PHY_WIDTH+3-bit signed arithmetic without wrap. Screen left column SHALL be left = char_pos_x.
REQ-007 Hit SHALL be defined as 0 <= (pixel_x-left) < CHAR_WIDTH_X and 0 <= (pixel_y-top) < CHAR_WIDTH_Y, both evaluated signed. Partially or fully off-screen sprites (negative left/top) SHALL clip correctly with no wrap-around.
REQ-008 Texel column SHALL be col = pixel_x-left when shadow face >= 0, and CHAR_WIDTH_X-1-(pixel_x-left) when face = -1 (mirror). Row SHALL be row = pixel_y-top.
REQ-009 Sprite ROM SHALL hold 4 frames of CHAR_WIDTH_X x CHAR_WIDTH_Y 2-bit palette indices. Built-in contents: frame n, column 0 = index 0; all other texels = index (n mod 3)+1.
REQ-010 Palette: index 0 = transparent; 1 = 12'hF00; 2 = 12'h0F0; 3 = 12'h00F.
REQ-011 Frame select from shadow state: 0/5/6/other -> frame 0; 1 or 2 -> frame 1+walk_phase; 3 or 4 -> frame 3.
REQ-012 Animation counter SHALL increment on each frame_start while shadow state is 1 or 2; at ANIM_DIV it SHALL clear and walk_phase SHALL toggle. In any other state the counter and walk_phase SHALL clear to 0 on frame_start.
REQ-013 Pipeline: stage 1 registers hit, row, col, frame and bg_rgb; stage 2 registers ROM/palette result. Latency SHALL be exactly 2 cycles, fully pipelined with one pixel per cycle and no stalls.
REQ-014 rgb_valid(t+2) SHALL equal pixel_valid(t). When hit and index != 0: rgb_out = palette colour and in_sprite = 1. Otherwise rgb_out = bg_rgb(t) and in_sprite = 0. When rgb_valid = 0: rgb_out = 0 and in_sprite = 0.
REQ-015 frame_start coinciding with pixel_valid: that pixel SHALL use the old shadow values; the new values SHALL apply from the next cycle.
REQ-016 char_face = 0 SHALL render unmirrored.

Reset
REQ-017 On reset assertion, rgb_out = 0, rgb_valid = 0, in_sprite = 0, pipeline valid bits = 0, shadow registers = 0, shadow_valid = 0, anim counter = 0, walk_phase = 0, all immediately and asynchronously.
REQ-018 Reset asserted mid-frame SHALL discard in-flight pixels. After release, no sprite SHALL be drawn until the next frame_start.

Verification
REQ-019 Latch frame with pos_x=304, pos_y=84, face=1, state=0. Pixel (305,364) -> 2 cycles later rgb_out=12'hF00, in_sprite=1. Pixel (304,364) -> rgb_out=bg_rgb, in_sprite=0 (column 0 transparent).
REQ-020 Same setup with face=-1. Pixel (335,364) -> rgb_out=bg_rgb. Pixel (304,364) -> 12'hF00.
REQ-021 state=1 held for 8 frame_starts -> frame 1 (12'h0F0) before the 8th, frame 2 (12'h00F) after. Switching to state=0 -> 12'hF00 and counter cleared.
REQ-022 pos_x=-10, pos_y=84 -> pixels x=0..21 on row 364 drawn, x=22 not drawn, no wrapped pixels near x=630..639. pos_y=500 -> no pixel drawn.
REQ-023 Change char_pos_x mid-frame without frame_start -> output unchanged until the cycle after the next frame_start. Pulse frame_start with pixel_valid high -> that pixel uses the old position.
REQ-024 Assert reset with 2 pixels in flight -> rgb_valid=0 and rgb_out=0 immediately. After release, a hit pixel before any frame_start -> bg_rgb.

Source files
------------

// File: rtl/character_renderer_if.sv
// Pixel stream, character state and composited output of the character renderer.
interface character_renderer_if #(
    parameter int unsigned PHY_WIDTH   = 10,
    parameter int unsigned PIXEL_WIDTH = 12
);
    logic                          frame_start;
    logic                          pixel_valid;
    logic [9:0]                    pixel_x;
    logic [9:0]                    pixel_y;
    logic [PIXEL_WIDTH-1:0]        bg_rgb;
    logic signed [PHY_WIDTH:0]     char_pos_x;
    logic signed [PHY_WIDTH:0]     char_pos_y;
    logic signed [1:0]             char_face;
    logic [3:0]                    char_state;
    logic [PIXEL_WIDTH-1:0]        rgb_out;
    logic                          rgb_valid;
    logic                          in_sprite;

    // Video timing / physics side.
    modport master (
        output frame_start, pixel_valid, pixel_x, pixel_y, bg_rgb,
               char_pos_x, char_pos_y, char_face, char_state,
        input  rgb_out, rgb_valid, in_sprite
    );

    // Renderer side.
    modport slave (
        input  frame_start, pixel_valid, pixel_x, pixel_y, bg_rgb,
               char_pos_x, char_pos_y, char_face, char_state,
        output rgb_out, rgb_valid, in_sprite
    );
endinterface

// File: rtl/character_renderer.sv
// Two-stage sprite compositor: overlays a 4-frame animated character on the background.
module character_renderer #(
    parameter int unsigned PHY_WIDTH    = 10,
    parameter int unsigned PIXEL_WIDTH  = 12,
    parameter int unsigned CHAR_WIDTH_X = 32,
    parameter int unsigned CHAR_WIDTH_Y = 32,
    parameter int unsigned Y_ORIGIN     = 479,
    parameter int unsigned ANIM_DIV     = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    character_renderer_if.slave  bus
);
    localparam int unsigned SW        = PHY_WIDTH + 3;
    localparam int unsigned COL_W     = (CHAR_WIDTH_X > 1) ? $clog2(CHAR_WIDTH_X) : 1;
    localparam int unsigned ROW_W     = (CHAR_WIDTH_Y > 1) ? $clog2(CHAR_WIDTH_Y) : 1;
    localparam int unsigned TEXELS    = CHAR_WIDTH_X * CHAR_WIDTH_Y;
    localparam int unsigned ROM_DEPTH = 4 * TEXELS;
    localparam int unsigned ADDR_W    = $clog2(ROM_DEPTH);
    localparam int unsigned CNT_W     = $clog2(ANIM_DIV + 1);

    // Built-in sprite sheet: column 0 transparent, rest of frame n uses index (n mod 3)+1.
    function automatic logic [2*ROM_DEPTH-1:0] rom_init();
        logic [2*ROM_DEPTH-1:0] img;
        img = '0;
        for (int unsigned f = 0; f < 4; f++)
            for (int unsigned r = 0; r < CHAR_WIDTH_Y; r++)
                for (int unsigned c = 0; c < CHAR_WIDTH_X; c++)
                    img[2*(f*TEXELS + r*CHAR_WIDTH_X + c) +: 2] = (c == 0) ? 2'd0 : 2'(f % 3 + 1);
        return img;
    endfunction

    localparam logic [2*ROM_DEPTH-1:0] SPRITE_ROM = rom_init();

    // Palette index to colour; index 0 is transparent and never looked up.
    function automatic logic [PIXEL_WIDTH-1:0] palette(input logic [1:0] idx);
        case (idx)
            2'd1:    return PIXEL_WIDTH'(12'hF00);
            2'd2:    return PIXEL_WIDTH'(12'h0F0);
            2'd3:    return PIXEL_WIDTH'(12'h00F);
            default: return '0;
        endcase
    endfunction

    logic signed [PHY_WIDTH:0] sh_x;
    logic signed [PHY_WIDTH:0] sh_y;
    logic signed [1:0]         sh_face;
    logic [3:0]                sh_state;
    logic                      sh_valid;
    logic [CNT_W-1:0]          anim_cnt;
    logic                      walk_phase;

    logic signed [SW-1:0]      left_s;
    logic signed [SW-1:0]      top_s;
    logic signed [SW-1:0]      dx;
    logic signed [SW-1:0]      dy;
    logic                      hit_c;
    logic [COL_W-1:0]          col_c;
    logic [1:0]                frame_c;

    logic                      s1_valid;
    logic                      s1_hit;
    logic [ROW_W-1:0]          s1_row;
    logic [COL_W-1:0]          s1_col;
    logic [1:0]                s1_frame;
    logic [PIXEL_WIDTH-1:0]    s1_bg;

    logic [ADDR_W-1:0]         rom_addr;
    logic [1:0]                texel_idx;

    // Latch character state once per frame; the state being latched drives the walk animation.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_x       <= '0;
            sh_y       <= '0;
            sh_face    <= '0;
            sh_state   <= '0;
            sh_valid   <= 1'b0;
            anim_cnt   <= '0;
            walk_phase <= 1'b0;
        end else if (bus.frame_start) begin
            sh_x     <= bus.char_pos_x;
            sh_y     <= bus.char_pos_y;
            sh_face  <= bus.char_face;
            sh_state <= bus.char_state;
            sh_valid <= 1'b1;
            if (bus.char_state == 4'd1 || bus.char_state == 4'd2) begin
                if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
                    anim_cnt   <= '0;
                    walk_phase <= ~walk_phase;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end else begin
                anim_cnt   <= '0;
                walk_phase <= 1'b0;
            end
        end
    end

    // Sprite-relative coordinates, widened so off-screen positions never wrap.
    assign left_s = SW'(sh_x);
    assign top_s  = $signed(SW'(Y_ORIGIN)) - SW'(sh_y) - $signed(SW'(CHAR_WIDTH_Y - 1));
    assign dx     = $signed(SW'(bus.pixel_x)) - left_s;
    assign dy     = $signed(SW'(bus.pixel_y)) - top_s;

    // Hit test, mirroring and animation frame selection.
    always_comb begin
        hit_c = sh_valid
              && (dx >= 0) && (dx < $signed(SW'(CHAR_WIDTH_X)))
              && (dy >= 0) && (dy < $signed(SW'(CHAR_WIDTH_Y)));
        col_c = (sh_face == 2'sb11) ? COL_W'(CHAR_WIDTH_X - 1) - COL_W'(dx) : COL_W'(dx);
        case (sh_state)
            4'd1, 4'd2: frame_c = 2'd1 + {1'b0, walk_phase};
            4'd3, 4'd4: frame_c = 2'd3;
            default:    frame_c = 2'd0;
        endcase
    end

    // Stage 1: register hit test results alongside the background pixel.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_frame <= '0;
            s1_bg    <= '0;
        end else begin
            s1_valid <= bus.pixel_valid;
            s1_hit   <= hit_c;
            s1_row   <= ROW_W'(dy);
            s1_col   <= col_c;
            s1_frame <= frame_c;
            s1_bg    <= bus.bg_rgb;
        end
    end

    assign rom_addr  = ADDR_W'(s1_frame) * ADDR_W'(TEXELS)
                     + ADDR_W'(s1_row) * ADDR_W'(CHAR_WIDTH_X)
                     + ADDR_W'(s1_col);
    assign texel_idx = SPRITE_ROM[{rom_addr, 1'b0} +: 2];

    // Stage 2: composite the texel over the background.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.rgb_out   <= '0;
            bus.rgb_valid <= 1'b0;
            bus.in_sprite <= 1'b0;
        end else begin
            bus.rgb_valid <= s1_valid;
            if (s1_valid && s1_hit && texel_idx != 2'd0) begin
                bus.rgb_out   <= palette(texel_idx);
                bus.in_sprite <= 1'b1;
            end else if (s1_valid) begin
                bus.rgb_out   <= s1_bg;
                bus.in_sprite <= 1'b0;
            end else begin
                bus.rgb_out   <= '0;
                bus.in_sprite <= 1'b0;
            end
        end
    end
endmodule
